// File: rtl/battle_pkg.sv
// Shared encodings for the battle screen sequencer: phase states, key codes
// and default HP values.
package battle_pkg;

    typedef enum logic [2:0] {
        ST_HOME        = 3'd0,
        ST_MENU        = 3'd1,
        ST_PLAYER_ATK  = 3'd2,
        ST_MONSTER_ATK = 3'd3,
        ST_RESULT      = 3'd4
    } state_t;

    localparam logic [7:0] KEY_ENTER = 8'h0D;
    localparam logic [7:0] KEY_HEAL  = 8'h68;

    localparam int DEF_PLAYER_HP_MAX  = 300;
    localparam int DEF_MONSTER_HP_MAX = 500;

endpackage

// File: rtl/sec_timer.sv
// Seconds countdown: a prescaler dividing the system clock into one-second
// ticks driving an 8-bit loadable down-counter.
module sec_timer #(
    parameter int CLKS_PER_SEC = 100000000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_clear,
    input  logic       i_run,
    output logic [7:0] o_count,
    output logic       o_zero,
    output logic       o_expire
);

    localparam int PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_SEC - 1);

    logic [PW-1:0] presc_q;
    logic [7:0]    count_q;
    logic          tick;

    assign tick     = i_run && (presc_q == PRESC_LAST);
    assign o_count  = count_q;
    assign o_zero   = (count_q == 8'd0);
    // High on the cycle whose edge will take the count from 1 to 0.
    assign o_expire = tick && (count_q == 8'd1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_q <= '0;
            count_q <= '0;
        end else if (i_load) begin
            presc_q <= '0;
            count_q <= i_load_val;
        end else if (i_clear || !i_run) begin
            presc_q <= '0;
            count_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
            count_q <= (count_q != 8'd0) ? count_q - 8'd1 : 8'd0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

endmodule

// File: rtl/battle_sequencer.sv
// Battle screen phase controller: HOME/MENU/PLAYER_ATK/MONSTER_ATK/RESULT with
// HP bookkeeping and attack countdown. Heal support is built when BATTLE_HEAL_EN is defined.
module battle_sequencer
    import battle_pkg::*;
#(
    parameter int HP_W           = 16,
    parameter int DMG_W          = 8,
    parameter int PLAYER_HP_MAX  = DEF_PLAYER_HP_MAX,
    parameter int MONSTER_HP_MAX = DEF_MONSTER_HP_MAX,
    parameter int CLKS_PER_SEC   = 100000000,
    parameter int ATTACK_SECS    = 6,
    parameter int HEAL_AMT       = 50,
    parameter int HEAL_LIMIT     = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_key_valid,
    input  logic [7:0]       i_key_code,
    input  logic             i_bar_stop,
    input  logic [DMG_W-1:0] i_hit_dmg,
    input  logic             i_player_hit,
    input  logic [DMG_W-1:0] i_player_dmg,
    output logic [2:0]       o_state,
    output logic             o_bar_active,
    output logic             o_attack_active,
    output logic [HP_W-1:0]  o_player_hp,
    output logic [HP_W-1:0]  o_monster_hp,
    output logic [7:0]       o_sec_left,
    output logic             o_win,
    output logic [1:0]       o_heals_left
);

    localparam logic [HP_W-1:0] P_MAX = HP_W'(PLAYER_HP_MAX);
    localparam logic [HP_W-1:0] M_MAX = HP_W'(MONSTER_HP_MAX);

    state_t          state_q;
    logic [HP_W-1:0] player_hp_q, monster_hp_q;
    logic            win_q;
    logic [HP_W-1:0] hit_ext, pdmg_ext, monster_after, player_after;
    logic            key_enter, death, tmr_load, tmr_clear, tmr_run;
    logic            tmr_zero, tmr_expire, tmr_done;

    // Key, bar and hit inputs are single-cycle strobes with no back-pressure:
    // each is consumed on the edge it is seen or dropped.
    assign key_enter     = i_key_valid && (i_key_code == KEY_ENTER);
    assign hit_ext       = HP_W'(i_hit_dmg);
    assign pdmg_ext      = HP_W'(i_player_dmg);
    assign monster_after = (monster_hp_q > hit_ext)  ? monster_hp_q - hit_ext  : '0;
    assign player_after  = (player_hp_q  > pdmg_ext) ? player_hp_q  - pdmg_ext : '0;

    assign tmr_run   = (state_q == ST_MONSTER_ATK);
    assign death     = tmr_run && i_player_hit && (player_after == '0);
    assign tmr_done  = tmr_expire || tmr_zero;
    assign tmr_load  = (state_q == ST_PLAYER_ATK) && i_bar_stop && (monster_after != '0);
    assign tmr_clear = tmr_run && (death || tmr_done);

    sec_timer #(.CLKS_PER_SEC(CLKS_PER_SEC)) u_sec_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (tmr_load),
        .i_load_val (8'(ATTACK_SECS)),
        .i_clear    (tmr_clear),
        .i_run      (tmr_run),
        .o_count    (o_sec_left),
        .o_zero     (tmr_zero),
        .o_expire   (tmr_expire)
    );

`ifdef BATTLE_HEAL_EN
    localparam logic [1:0] HEALS_INIT = 2'(HEAL_LIMIT);
    logic [1:0]    heals_q;
    logic [HP_W:0] heal_sum;
    logic          key_heal;
    assign key_heal     = i_key_valid && (i_key_code == KEY_HEAL);
    assign heal_sum     = {1'b0, player_hp_q} + (HP_W + 1)'(HEAL_AMT);
    assign o_heals_left = heals_q;
`else
    assign o_heals_left = 2'd0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_HOME;
            player_hp_q  <= P_MAX;
            monster_hp_q <= M_MAX;
            win_q        <= 1'b0;
`ifdef BATTLE_HEAL_EN
            heals_q      <= HEALS_INIT;
`endif
        end else begin
            case (state_q)
                ST_HOME: if (key_enter) begin
                    state_q      <= ST_MENU;
                    player_hp_q  <= P_MAX;
                    monster_hp_q <= M_MAX;
                    win_q        <= 1'b0;
`ifdef BATTLE_HEAL_EN
                    heals_q      <= HEALS_INIT;
`endif
                end
                ST_MENU: begin
                    if (key_enter) begin
                        state_q <= ST_PLAYER_ATK;
                    end
`ifdef BATTLE_HEAL_EN
                    else if (key_heal && heals_q != 2'd0) begin
                        player_hp_q <= (heal_sum > {1'b0, P_MAX}) ? P_MAX : heal_sum[HP_W-1:0];
                        heals_q     <= heals_q - 2'd1;
                    end
`endif
                end
                ST_PLAYER_ATK: if (i_bar_stop) begin
                    monster_hp_q <= monster_after;
                    if (monster_after == '0) begin
                        state_q <= ST_RESULT;
                        win_q   <= 1'b1;
                    end else begin
                        state_q <= ST_MONSTER_ATK;
                    end
                end
                ST_MONSTER_ATK: begin
                    if (i_player_hit) player_hp_q <= player_after;
                    // A killing hit outranks the countdown ending on the same edge.
                    if (death) begin
                        state_q <= ST_RESULT;
                        win_q   <= 1'b0;
                    end else if (tmr_done) begin
                        state_q <= ST_MENU;
                    end
                end
                ST_RESULT: if (key_enter) state_q <= ST_HOME;
                default: state_q <= ST_HOME;
            endcase
        end
    end

    assign o_state         = state_q;
    assign o_bar_active    = (state_q == ST_PLAYER_ATK);
    assign o_attack_active = (state_q == ST_MONSTER_ATK);
    assign o_player_hp     = player_hp_q;
    assign o_monster_hp    = monster_hp_q;
    assign o_win           = win_q;

endmodule

// File: tb/tb_battle_sequencer.sv
// Directed bench for battle_sequencer with a 10-cycle second and 3-second attack phase.
// Builds with or without BATTLE_HEAL_EN.
module tb_battle_sequencer;

    localparam int HP_W = 16;
    localparam int DMG_W = 8;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_key_valid = 1'b0;
    logic [7:0]       i_key_code = 8'd0;
    logic             i_bar_stop = 1'b0;
    logic [DMG_W-1:0] i_hit_dmg = '0;
    logic             i_player_hit = 1'b0;
    logic [DMG_W-1:0] i_player_dmg = '0;
    logic [2:0]       o_state;
    logic             o_bar_active, o_attack_active, o_win;
    logic [HP_W-1:0]  o_player_hp, o_monster_hp;
    logic [7:0]       o_sec_left;
    logic [1:0]       o_heals_left;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    battle_sequencer #(
        .HP_W(HP_W), .DMG_W(DMG_W), .PLAYER_HP_MAX(300), .MONSTER_HP_MAX(500),
        .CLKS_PER_SEC(10), .ATTACK_SECS(3), .HEAL_AMT(50), .HEAL_LIMIT(3)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_key_valid(i_key_valid), .i_key_code(i_key_code),
        .i_bar_stop(i_bar_stop), .i_hit_dmg(i_hit_dmg), .i_player_hit(i_player_hit),
        .i_player_dmg(i_player_dmg), .o_state(o_state), .o_bar_active(o_bar_active),
        .o_attack_active(o_attack_active), .o_player_hp(o_player_hp), .o_monster_hp(o_monster_hp),
        .o_sec_left(o_sec_left), .o_win(o_win), .o_heals_left(o_heals_left)
    );

    // Clock / reset
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
        end
    endtask

    // Driver tasks: inputs change at the falling edge, so each call occupies
    // exactly one rising edge and returns at the next falling edge.
    task automatic send_key(input logic [7:0] code);
        i_key_valid = 1'b1; i_key_code = code;
        @(negedge i_clk);
        i_key_valid = 1'b0; i_key_code = 8'd0;
    endtask

    task automatic bar_stop(input logic [DMG_W-1:0] dmg);
        i_bar_stop = 1'b1; i_hit_dmg = dmg;
        @(negedge i_clk);
        i_bar_stop = 1'b0; i_hit_dmg = '0;
    endtask

    task automatic player_hit(input logic [DMG_W-1:0] dmg);
        i_player_hit = 1'b1; i_player_dmg = dmg;
        @(negedge i_clk);
        i_player_hit = 1'b0; i_player_dmg = '0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge i_clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(o_state), 0);
        check({tag, "_php"}, 32'(o_player_hp), 300);
        check({tag, "_mhp"}, 32'(o_monster_hp), 500);
        check({tag, "_sec"}, 32'(o_sec_left), 0);
        check({tag, "_win"}, 32'(o_win), 0);
        check({tag, "_bar"}, 32'(o_bar_active), 0);
        check({tag, "_atk"}, 32'(o_attack_active), 0);
`ifdef BATTLE_HEAL_EN
        check({tag, "_heals"}, 32'(o_heals_left), 3);
`else
        check({tag, "_heals"}, 32'(o_heals_left), 0);
`endif
    endtask

    initial begin
        wait_cycles(3);
        check_reset_values("rst");
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // New game, into PLAYER_ATK
        send_key(8'h0D);
        check("menu_state", 32'(o_state), 1);
        send_key(8'h0D);
        check("patk_state", 32'(o_state), 2);
        check("patk_bar", 32'(o_bar_active), 1);
        check("patk_php", 32'(o_player_hp), 300);
        check("patk_mhp", 32'(o_monster_hp), 500);

        // Bar hit 120, then a full countdown with no hits
        bar_stop(8'd120);
        check("hit120_mhp", 32'(o_monster_hp), 380);
        check("hit120_state", 32'(o_state), 3);
        check("hit120_sec", 32'(o_sec_left), 3);
        check("hit120_atk", 32'(o_attack_active), 1);
        for (int k = 1; k <= 30; k++) exp_q.push_back(8'(k < 10 ? 3 : k < 20 ? 2 : k < 30 ? 1 : 0));
        for (int k = 1; k <= 30; k++) begin
            @(negedge i_clk);
            check($sformatf("cd_sec_%0d", k), 32'(o_sec_left), 32'(exp_q.pop_front()));
            check($sformatf("cd_state_%0d", k), 32'(o_state), (k == 30) ? 1 : 3);
        end

        // Ignored bar stop outside PLAYER_ATK
        bar_stop(8'd50);
        check("ign_bar_mhp", 32'(o_monster_hp), 380);
        check("ign_bar_state", 32'(o_state), 1);

        // Bring monster to 100, then overkill
        send_key(8'h0D);
        bar_stop(8'd200);
        check("m180", 32'(o_monster_hp), 180);
        wait_cycles(30);
        check("m180_menu", 32'(o_state), 1);
        send_key(8'h0D);
        bar_stop(8'd80);
        check("m100", 32'(o_monster_hp), 100);
        wait_cycles(30);
        send_key(8'h0D);
        check("m100_patk", 32'(o_state), 2);
        bar_stop(8'd200);
        check("kill_mhp", 32'(o_monster_hp), 0);
        check("kill_state", 32'(o_state), 4);
        check("kill_win", 32'(o_win), 1);
        check("kill_sec", 32'(o_sec_left), 0);
        send_key(8'h0D);
        check("home_state", 32'(o_state), 0);
        check("home_mhp_frozen", 32'(o_monster_hp), 0);
        send_key(8'h0D);
        check("reload_state", 32'(o_state), 1);
        check("reload_php", 32'(o_player_hp), 300);
        check("reload_mhp", 32'(o_monster_hp), 500);
        check("reload_win", 32'(o_win), 0);

        // Player death on the same edge the countdown expires
        send_key(8'h0D);
        bar_stop(8'd10);
        check("d_mhp", 32'(o_monster_hp), 490);
        player_hit(8'd255);
        check("d_php45", 32'(o_player_hp), 45);
        player_hit(8'd35);
        check("d_php10", 32'(o_player_hp), 10);
        player_hit(8'd0);
        check("d_zero_php", 32'(o_player_hp), 10);
        check("d_zero_state", 32'(o_state), 3);
        wait_cycles(26);
        check("d_pre_sec", 32'(o_sec_left), 1);
        player_hit(8'd10);
        check("d_state", 32'(o_state), 4);
        check("d_win", 32'(o_win), 0);
        check("d_php", 32'(o_player_hp), 0);
        check("d_sec", 32'(o_sec_left), 0);

        // Asynchronous reset mid-MONSTER_ATK
        send_key(8'h0D);
        send_key(8'h0D);
        send_key(8'h0D);
        bar_stop(8'd50);
        wait_cycles(5);
        check("ar_state_pre", 32'(o_state), 3);
        #2 i_rst_n = 1'b0;
        #1 check_reset_values("arst");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Heal path: player at 280 in MENU
        send_key(8'h0D);
        send_key(8'h0D);
        bar_stop(8'd1);
        player_hit(8'd20);
        wait_cycles(29);
        check("h_state", 32'(o_state), 1);
        check("h_php", 32'(o_player_hp), 280);
        send_key(8'h68);
`ifdef BATTLE_HEAL_EN
        check("h1_php", 32'(o_player_hp), 300);
        check("h1_heals", 32'(o_heals_left), 2);
        send_key(8'h68);
        send_key(8'h68);
        check("h3_heals", 32'(o_heals_left), 0);
        send_key(8'h68);
        check("h4_heals", 32'(o_heals_left), 0);
        check("h4_php", 32'(o_player_hp), 300);
`else
        check("h1_php", 32'(o_player_hp), 280);
        check("h1_heals", 32'(o_heals_left), 0);
`endif
        check("h_state_after", 32'(o_state), 1);
        send_key(8'h41);
        check("other_key_state", 32'(o_state), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
